// File: rtl/scc_pkg.sv
// Shared definitions for the SCC wave-RAM access scheduler.
// Holds the FSM state encoding, request field widths, the mixer scan-phase
// upper bound and the data value returned when a read never completes.
package scc_pkg;

  localparam int unsigned ID_W       = 3;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned ACTIVE_MAX = 5;

  localparam logic [DATA_W-1:0] RD_ERR_DATA = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SLOT,
    ST_ISSUE,
    ST_READ_WAIT
  } scc_state_e;

  typedef struct packed {
    logic              wr;
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wdata;
  } scc_req_t;

  // Phases 6 and 7 lie outside the mixer scan and are never issue slots.
  function automatic logic slot_permitted(input logic [5:0] mask,
                                          input logic [2:0] phase);
    logic [7:0] mask_ext;
    mask_ext = {2'b00, mask};
    return (phase <= 3'(ACTIVE_MAX)) ? mask_ext[phase] : 1'b0;
  endfunction

endpackage

// File: rtl/scc_req_fifo.sv
// 2-deep register FIFO holding pending CPU requests.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   push_i/din_i - write an entry (ignored when full)
//   pop_i        - drop the head entry (ignored when empty)
//   head_o       - current head entry
//   count_o      - number of valid entries (0..2)
import scc_pkg::*;

module scc_req_fifo (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic       pop_i,
  input  scc_req_t   din_i,
  output scc_req_t   head_o,
  output logic [1:0] count_o
);

  scc_req_t   mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       do_push;
  logic       do_pop;

  assign do_push = push_i && (count_q != 2'd2);
  assign do_pop  = pop_i && (count_q != 2'd0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/scc_sram_access_scheduler.sv
// Sequences CPU wave-RAM requests onto the SCC mixer's shared SRAM port.
// Requests queue in a 2-entry FIFO and are issued one at a time as a single
// enable-period sram_oe/sram_we strobe in a permitted mixer scan phase; read
// data returns in order on bus_rdata with a one-clk bus_rdata_valid pulse.
// Ports:
//   clk, reset, enable         - clock, async active-high reset, mixer tick
//   bus_valid/bus_ready        - request handshake (push when both high)
//   bus_wr/id/a/wdata          - request fields
//   bus_rdata/bus_rdata_valid  - read return
//   sram_id/a/d, sram_oe/we    - mixer-side request
//   sram_q/sram_q_en           - mixer read data
//   active                     - mixer scan phase
//   busy                       - work pending
import scc_pkg::*;

module scc_sram_access_scheduler #(
  parameter logic [5:0]  SLOT_MASK = 6'b011110,
  parameter int unsigned MAX_WAIT  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              bus_valid,
  output logic              bus_ready,
  input  logic              bus_wr,
  input  logic [ID_W-1:0]   bus_id,
  input  logic [ADDR_W-1:0] bus_a,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              bus_rdata_valid,
  output logic [ID_W-1:0]   sram_id,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  output logic              sram_oe,
  output logic              sram_we,
  input  logic [DATA_W-1:0] sram_q,
  input  logic              sram_q_en,
  input  logic [2:0]        active,
  output logic              busy
);

  scc_req_t   push_req;
  scc_req_t   head;
  logic [1:0] fifo_count;
  logic       push;
  logic       pop;
  logic       issue_now;
  scc_state_e done_state;

  scc_state_e state_q;
  logic [7:0] wait_cnt_q;
  logic       cur_wr_q;

  assign push_req  = '{wr: bus_wr, id: bus_id, a: bus_a, wdata: bus_wdata};
  assign bus_ready = (fifo_count != 2'd2);
  assign push      = bus_valid && bus_ready;
  assign busy      = (fifo_count != 2'd0) || (state_q != ST_IDLE);

  assign issue_now = (state_q == ST_WAIT_SLOT) &&
                     (slot_permitted(SLOT_MASK, active) || (wait_cnt_q == 8'(MAX_WAIT)));
  // The head is captured into sram_* on the issuing tick, so it leaves the
  // FIFO right then; this frees a slot one enable period earlier.
  assign pop        = enable && issue_now;
  assign done_state = (fifo_count != 2'd0) ? ST_WAIT_SLOT : ST_IDLE;

  scc_req_fifo u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (push_req),
    .head_o  (head),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      wait_cnt_q      <= '0;
      cur_wr_q        <= 1'b0;
      bus_rdata       <= '0;
      bus_rdata_valid <= 1'b0;
      sram_id         <= '0;
      sram_a          <= '0;
      sram_d          <= '0;
      sram_oe         <= 1'b0;
      sram_we         <= 1'b0;
    end else begin
      bus_rdata_valid <= 1'b0;
      if (enable) begin
        unique case (state_q)
          ST_IDLE: begin
            if (fifo_count != 2'd0) begin
              state_q    <= ST_WAIT_SLOT;
              wait_cnt_q <= '0;
            end
          end
          ST_WAIT_SLOT: begin
            if (issue_now) begin
              state_q  <= ST_ISSUE;
              sram_id  <= head.id;
              sram_a   <= head.a;
              sram_d   <= head.wdata;
              sram_oe  <= ~head.wr;
              sram_we  <= head.wr;
              cur_wr_q <= head.wr;
            end else if (wait_cnt_q != 8'(MAX_WAIT)) begin
              wait_cnt_q <= wait_cnt_q + 8'd1;
            end
          end
          ST_ISSUE: begin
            sram_oe    <= 1'b0;
            sram_we    <= 1'b0;
            wait_cnt_q <= '0;
            state_q    <= cur_wr_q ? done_state : ST_READ_WAIT;
          end
          ST_READ_WAIT: begin
            // Second tick without sram_q_en gives up and returns the error value.
            if (sram_q_en || (wait_cnt_q == 8'd1)) begin
              bus_rdata       <= sram_q_en ? sram_q : RD_ERR_DATA;
              bus_rdata_valid <= 1'b1;
              wait_cnt_q      <= '0;
              state_q         <= done_state;
            end else begin
              wait_cnt_q <= wait_cnt_q + 8'd1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scc_sram_access_scheduler.sv
// Self-checking bench for scc_sram_access_scheduler: table of requests with
// expected read data, a scoreboard of expected strobes/read returns, a small
// mixer model, and hand-written corner sequences.
module tb_scc_sram_access_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       bus_valid = 1'b0;
  logic       bus_ready;
  logic       bus_wr = 1'b0;
  logic [2:0] bus_id = '0;
  logic [4:0] bus_a = '0;
  logic [7:0] bus_wdata = '0;
  logic [7:0] bus_rdata;
  logic       bus_rdata_valid;
  logic [2:0] sram_id;
  logic [4:0] sram_a;
  logic [7:0] sram_d;
  logic       sram_oe;
  logic       sram_we;
  logic [7:0] sram_q;
  logic       sram_q_en;
  logic [2:0] active = 3'd0;
  logic       busy;

  // Second instance for the starvation guard: only phase 0 permitted.
  logic       s_bus_valid = 1'b0;
  logic       s_bus_ready;
  logic       s_bus_wr = 1'b0;
  logic [2:0] s_bus_id = '0;
  logic [4:0] s_bus_a = '0;
  logic [7:0] s_bus_wdata = '0;
  logic [7:0] s_bus_rdata;
  logic       s_bus_rdata_valid;
  logic [2:0] s_sram_id;
  logic [4:0] s_sram_a;
  logic [7:0] s_sram_d;
  logic       s_sram_oe;
  logic       s_sram_we;
  logic [7:0] s_sram_q = '0;
  logic       s_sram_q_en = 1'b0;
  logic [2:0] s_active = 3'd3;
  logic       s_busy;

  int checks = 0;
  int errors = 0;

  scc_sram_access_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_wr(bus_wr),
    .bus_id(bus_id), .bus_a(bus_a), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_rdata_valid(bus_rdata_valid),
    .sram_id(sram_id), .sram_a(sram_a), .sram_d(sram_d),
    .sram_oe(sram_oe), .sram_we(sram_we), .sram_q(sram_q),
    .sram_q_en(sram_q_en), .active(active), .busy(busy)
  );

  scc_sram_access_scheduler #(.SLOT_MASK(6'b000001), .MAX_WAIT(8)) dut_s (
    .clk(clk), .reset(reset), .enable(enable),
    .bus_valid(s_bus_valid), .bus_ready(s_bus_ready), .bus_wr(s_bus_wr),
    .bus_id(s_bus_id), .bus_a(s_bus_a), .bus_wdata(s_bus_wdata),
    .bus_rdata(s_bus_rdata), .bus_rdata_valid(s_bus_rdata_valid),
    .sram_id(s_sram_id), .sram_a(s_sram_a), .sram_d(s_sram_d),
    .sram_oe(s_sram_oe), .sram_we(s_sram_we), .sram_q(s_sram_q),
    .sram_q_en(s_sram_q_en), .active(s_active), .busy(s_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Enable pattern: high on every en_period-th clk, changed at negedges.
  int en_period = 1;
  int cyc = 0;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      enable = (en_period == 1) || ((cyc % en_period) == 0);
    end
  end

  // Mixer model: wave RAM, one-tick read return, scan phase 0..5.
  logic [7:0] mem [256];
  logic       mute = 1'b0;
  logic [2:0] last_act = 3'd0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sram_q_en <= 1'b0;
      sram_q    <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (enable) begin
      sram_q_en <= sram_oe & ~mute;
      sram_q    <= mem[{sram_id, sram_a}];
      if (sram_we) mem[{sram_id, sram_a}] <= sram_d;
    end
  end

  always @(posedge clk) begin
    if (enable) begin
      last_act <= active;
      active   <= (active == 3'd5) ? 3'd0 : active + 3'd1;
    end
  end

  // Scoreboard
  typedef struct packed {
    logic       wr;
    logic [2:0] id;
    logic [4:0] a;
    logic [7:0] d;
  } iss_t;
  iss_t       iss_q[$];
  logic [7:0] rd_q[$];
  int pulse_cnt = 0;
  int rv_cnt = 0;
  int ready_low_cnt = 0;

  initial begin
    bit   in_pulse;
    bit   prev_rv;
    int   pw;
    iss_t e;
    in_pulse = 0;
    prev_rv  = 0;
    pw       = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (!bus_ready) ready_low_cnt++;
        if (sram_oe || sram_we) begin
          if (!in_pulse) begin
            in_pulse = 1;
            pw = 1;
            pulse_cnt++;
            chk("oe_we_exclusive", {31'b0, sram_oe & sram_we}, 0);
            chk("issue_slot_1to4", {31'b0, (last_act >= 3'd1) && (last_act <= 3'd4)}, 1);
            chk("issue_expected", {31'b0, iss_q.size() != 0}, 1);
            if (iss_q.size() != 0) begin
              e = iss_q.pop_front();
              chk("issue_we", {31'b0, sram_we}, {31'b0, e.wr});
              chk("issue_oe", {31'b0, sram_oe}, {31'b0, ~e.wr});
              chk("issue_id_a_d", {16'b0, sram_id, sram_a, sram_d}, {16'b0, e.id, e.a, e.d});
            end
          end else begin
            pw++;
          end
        end else if (in_pulse) begin
          in_pulse = 0;
          chk("strobe_width", pw, en_period);
        end
        if (bus_rdata_valid) begin
          rv_cnt++;
          chk("rdata_valid_1clk", {31'b0, prev_rv}, 0);
          chk("rdata_expected", {31'b0, rd_q.size() != 0}, 1);
          if (rd_q.size() != 0) chk("rdata", bus_rdata, rd_q.pop_front());
        end
        prev_rv = bus_rdata_valid;
      end else begin
        in_pulse = 0;
        prev_rv  = 0;
      end
    end
  end

  task automatic push_req(input bit wr, input logic [2:0] id, input logic [4:0] a,
                          input logic [7:0] d, input logic [7:0] exp, output int waited);
    bit ok;
    bit rdy;
    int n;
    ok = 0;
    n  = 0;
    bus_wr = wr; bus_id = id; bus_a = a; bus_wdata = d; bus_valid = 1'b1;
    while (!ok && n < 100) begin
      rdy = bus_ready;
      @(posedge clk);
      if (rdy) begin
        ok = 1;
        iss_q.push_back({wr, id, a, d});
        if (!wr) rd_q.push_back(exp);
      end else begin
        n++;
      end
      #1;
    end
    bus_valid = 1'b0;
    waited = n;
    if (!ok) chk("push_accept_timeout", 0, 1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk(name, {31'b0, busy}, 0);
  endtask

  typedef struct {
    bit         wr;
    logic [2:0] id;
    logic [4:0] a;
    logic [7:0] d;
    bit         mute;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[10];

  initial begin
    int w;
    int pc0;
    int rl0;
    int rv0;
    int n;
    bit found;

    vecs[0] = '{1'b1, 3'd2, 5'h0A, 8'h5C, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 3'd2, 5'h0A, 8'h00, 1'b0, 8'h5C};
    vecs[2] = '{1'b1, 3'd0, 5'h00, 8'h11, 1'b0, 8'h00};
    vecs[3] = '{1'b1, 3'd4, 5'h1F, 8'hA5, 1'b0, 8'h00};
    vecs[4] = '{1'b0, 3'd4, 5'h1F, 8'h00, 1'b0, 8'hA5};
    vecs[5] = '{1'b0, 3'd0, 5'h00, 8'h00, 1'b0, 8'h11};
    vecs[6] = '{1'b1, 3'd2, 5'h0A, 8'h3C, 1'b0, 8'h00};
    vecs[7] = '{1'b0, 3'd2, 5'h0A, 8'h00, 1'b0, 8'h3C};
    vecs[8] = '{1'b0, 3'd1, 5'h03, 8'h00, 1'b0, 8'h00};
    vecs[9] = '{1'b0, 3'd3, 5'h07, 8'h00, 1'b1, 8'hFF};  // no sram_q_en: error value

    // Reset values
    #7;
    chk("rst_bus_ready", {31'b0, bus_ready}, 1);
    chk("rst_bus_rdata", bus_rdata, 0);
    chk("rst_rdata_valid", {31'b0, bus_rdata_valid}, 0);
    chk("rst_sram_id_a_d", {16'b0, sram_id, sram_a, sram_d}, 0);
    chk("rst_oe_we", {30'b0, sram_oe, sram_we}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven single requests
    for (int i = 0; i < 10; i++) begin
      pc0 = pulse_cnt;
      rl0 = ready_low_cnt;
      mute = vecs[i].mute;
      push_req(vecs[i].wr, vecs[i].id, vecs[i].a, vecs[i].d, vecs[i].exp, w);
      wait_idle("vec_idle", 60);
      chk("vec_one_strobe", pulse_cnt - pc0, 1);
      chk("vec_ready_high", ready_low_cnt - rl0, 0);
      mute = 1'b0;
    end

    // Back-to-back: FIFO fills on the second push, third waits for a pop
    push_req(1'b1, 3'd3, 5'h01, 8'h21, 8'h00, w);
    push_req(1'b1, 3'd3, 5'h02, 8'h22, 8'h00, w);
    chk("b2b_full_ready_low", {31'b0, bus_ready}, 0);
    push_req(1'b0, 3'd3, 5'h01, 8'h00, 8'h21, w);
    chk("b2b_third_waited", {31'b0, w > 0}, 1);
    wait_idle("b2b_idle", 80);

    // Enable every 4th clk: strobes span 4 clks, rdata_valid stays 1 clk
    en_period = 4;
    repeat (4) @(negedge clk);
    rv0 = rv_cnt;
    push_req(1'b1, 3'd1, 5'h05, 8'h77, 8'h00, w);
    push_req(1'b0, 3'd1, 5'h05, 8'h00, 8'h77, w);
    wait_idle("gated_idle", 300);
    chk("gated_one_rdata", rv_cnt - rv0, 1);
    en_period = 1;
    repeat (4) @(negedge clk);

    chk("scoreboard_iss_empty", iss_q.size(), 0);
    chk("scoreboard_rd_empty", rd_q.size(), 0);

    // Starvation guard: phase 3 never permitted. One tick IDLE->WAIT_SLOT,
    // eight waiting ticks, then the forced issue: strobe after 10th tick.
    @(negedge clk);
    s_bus_wr = 1'b1; s_bus_id = 3'd4; s_bus_a = 5'h11; s_bus_wdata = 8'h99; s_bus_valid = 1'b1;
    @(posedge clk);
    #1 s_bus_valid = 1'b0;
    n = 0;
    found = 0;
    while (!found && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (s_sram_we) found = 1;
    end
    chk("starve_latency", n, 10);
    chk("starve_id_a_d", {16'b0, s_sram_id, s_sram_a, s_sram_d}, {16'b0, 3'd4, 5'h11, 8'h99});
    @(negedge clk);
    chk("starve_strobe_1tick", {31'b0, s_sram_we}, 0);

    // Asynchronous reset while a read sits in READ_WAIT
    push_req(1'b0, 3'd2, 5'h0A, 8'h00, 8'h3C, w);
    n = 0;
    while (!sram_oe && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rstrd_oe_seen", {31'b0, sram_oe}, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rstrd_oe", {31'b0, sram_oe}, 0);
    chk("rstrd_busy", {31'b0, busy}, 0);
    chk("rstrd_ready", {31'b0, bus_ready}, 1);
    chk("rstrd_rdata", bus_rdata, 0);
    rd_q.delete();
    iss_q.delete();
    rv0 = rv_cnt;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("rstrd_no_rdata_valid", rv_cnt - rv0, 0);
    chk("rstrd_idle", {31'b0, busy}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
